// File: rtl/ifetch.sv
// Instruction fetch with a direct-mapped one-word-per-line I-cache and static branch prediction.
// Latency: a cache hit issues on the next edge; a miss issues two edges after the memory strobe.
// Backpressure: stall holds pc and suppresses issue, misses are still requested; rdy=0 freezes everything.
module ifetch #(
    parameter int ICACHE_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    input  logic        stall,
    output logic        inst_done,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pre_j,
    output logic        mc_en,
    output logic [31:0] mc_pc,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);

    localparam int IDX_W = $clog2(ICACHE_SIZE);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    // Architectural state
    state_t                   state_q, state_d;
    logic [31:0]              pc_q, pc_d;
    logic                     inst_done_q, inst_done_d;
    logic [31:0]              inst_q, inst_d;
    logic [31:0]              inst_pc_q, inst_pc_d;
    logic                     inst_pre_j_q, inst_pre_j_d;
    logic                     mc_en_q, mc_en_d;
    logic [31:0]              mc_pc_q, mc_pc_d;
    logic [ICACHE_SIZE-1:0]   valid_q, valid_d;

    // Cache storage: only the valid bits need reset, tag/data are gated by valid
    logic [TAG_W-1:0]         tag_q  [ICACHE_SIZE];
    logic [31:0]              data_q [ICACHE_SIZE];

    // Lookup on the current pc
    logic [IDX_W-1:0]         rd_idx;
    logic [TAG_W-1:0]         rd_tag;
    logic                     hit;
    logic [31:0]              line;

    // Fill port, always addressed by the outstanding request
    logic                     wr_en;
    logic [IDX_W-1:0]         wr_idx;
    logic [TAG_W-1:0]         wr_tag;

    // Prediction
    logic [6:0]               opcode;
    logic [31:0]              j_imm;
    logic [31:0]              b_imm;
    logic                     pred_taken;
    logic [31:0]              pred_pc;

    assign rd_idx = pc_q[IDX_W+1:2];
    assign rd_tag = pc_q[31:IDX_W+2];
    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign line   = data_q[rd_idx];

    assign wr_idx = mc_pc_q[IDX_W+1:2];
    assign wr_tag = mc_pc_q[31:IDX_W+2];

    // Static prediction: JAL always taken, conditional branches taken only when backward
    always_comb begin
        opcode     = line[6:0];
        j_imm      = {{12{line[31]}}, line[19:12], line[20], line[30:21], 1'b0};
        b_imm      = {{20{line[31]}}, line[7], line[30:25], line[11:8], 1'b0};
        pred_taken = 1'b0;
        pred_pc    = pc_q + 32'd4;
        if (opcode == OP_JAL) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + j_imm;
        end else if (opcode == OP_BRANCH && line[31]) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + b_imm;
        end
    end

    // Next-state: fill completes first, rollback overrides control, then issue/miss in IDLE
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_done_d  = inst_done_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pre_j_d = inst_pre_j_q;
        mc_en_d      = mc_en_q;
        mc_pc_d      = mc_pc_q;
        valid_d      = valid_q;
        wr_en        = 1'b0;
        if (rdy) begin
            inst_done_d = 1'b0;
            // A fill is written even when a rollback arrives in the same cycle
            if (state_q == S_WAIT_MEM && mc_done) begin
                wr_en           = 1'b1;
                valid_d[wr_idx] = 1'b1;
                mc_en_d         = 1'b0;
                state_d         = S_IDLE;
            end
            if (rollback) begin
                pc_d    = rollback_pc;
                mc_en_d = 1'b0;
                state_d = S_IDLE;
            end else if (state_q == S_IDLE) begin
                if (hit) begin
                    if (!stall) begin
                        inst_done_d  = 1'b1;
                        inst_d       = line;
                        inst_pc_d    = pc_q;
                        inst_pre_j_d = pred_taken;
                        pc_d         = pred_pc;
                    end
                end else begin
                    mc_en_d = 1'b1;
                    mc_pc_d = pc_q;
                    state_d = S_WAIT_MEM;
                end
            end
        end
    end

    // FSM, pc, registered outputs and valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 32'd0;
            inst_done_q  <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_pre_j_q <= 1'b0;
            mc_en_q      <= 1'b0;
            mc_pc_q      <= 32'd0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_done_q  <= inst_done_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_pre_j_q <= inst_pre_j_d;
            mc_en_q      <= mc_en_d;
            mc_pc_q      <= mc_pc_d;
            valid_q      <= valid_d;
        end
    end

    // Tag/data fill from the memory response
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= mc_data;
        end
    end

    assign inst_done  = inst_done_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_pre_j = inst_pre_j_q;
    assign mc_en      = mc_en_q;
    assign mc_pc      = mc_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cold miss, hits, prediction, rollback, stall, rdy freeze, async reset.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the instruction encodings used below.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        stall;
    logic        inst_done;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pre_j;
    logic        mc_en;
    logic [31:0] mc_pc;
    logic        mc_done;
    logic [31:0] mc_data;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch #(.ICACHE_SIZE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .rollback_pc(rollback_pc),
        .stall      (stall),
        .inst_done  (inst_done),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_pre_j (inst_pre_j),
        .mc_en      (mc_en),
        .mc_pc      (mc_pc),
        .mc_done    (mc_done),
        .mc_data    (mc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle memory response strobe
    task automatic serve(input logic [31:0] data);
        mc_done = 1'b1;
        mc_data = data;
        tick();
        mc_done = 1'b0;
        mc_data = 32'd0;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] e_inst,
                                input logic [31:0] e_pc, input logic e_pj);
        check({tag, "_done"}, {31'd0, inst_done}, 32'd1);
        check({tag, "_inst"}, inst, e_inst);
        check({tag, "_pc"},   inst_pc, e_pc);
        check({tag, "_prej"}, {31'd0, inst_pre_j}, {31'd0, e_pj});
    endtask

    task automatic expect_req(input string tag, input logic [31:0] e_pc);
        check({tag, "_mc_en"}, {31'd0, mc_en}, 32'd1);
        check({tag, "_mc_pc"}, mc_pc, e_pc);
    endtask

    initial begin
        rst         = 1'b0;
        rdy         = 1'b1;
        rollback    = 1'b0;
        rollback_pc = 32'd0;
        stall       = 1'b0;
        mc_done     = 1'b0;
        mc_data     = 32'd0;

        // Reset values, before any clock edge
        #3;
        check("rst_inst_done", {31'd0, inst_done}, 32'd0);
        check("rst_inst",      inst, 32'd0);
        check("rst_inst_pc",   inst_pc, 32'd0);
        check("rst_pre_j",     {31'd0, inst_pre_j}, 32'd0);
        check("rst_mc_en",     {31'd0, mc_en}, 32'd0);
        check("rst_mc_pc",     mc_pc, 32'd0);
        rst = 1'b1;

        // Cold miss at 0x0, request held steady until the response
        tick();
        expect_req("cold", 32'h0);
        tick();
        expect_req("cold_hold1", 32'h0);
        tick();
        expect_req("cold_hold2", 32'h0);
        serve(32'h0000_0013);
        check("fill_mc_en", {31'd0, mc_en}, 32'd0);
        check("fill_no_issue", {31'd0, inst_done}, 32'd0);
        tick();
        expect_issue("nop0", 32'h0000_0013, 32'h0, 1'b0);

        // Sequential miss at 0x4
        tick();
        check("pulse_clear", {31'd0, inst_done}, 32'd0);
        expect_req("miss4", 32'h4);
        serve(32'h0000_0013);
        tick();
        expect_issue("nop4", 32'h0000_0013, 32'h4, 1'b0);

        // Backward branch at 0x8 predicted taken to 0x4, which hits
        tick();
        expect_req("miss8", 32'h8);
        serve(32'hFE00_0EE3);
        tick();
        expect_issue("beq8", 32'hFE00_0EE3, 32'h8, 1'b1);
        tick();
        expect_issue("loop4", 32'h0000_0013, 32'h4, 1'b0);

        // Rollback while pc=0x8 would hit: no issue, redirect to 0x10
        rollback    = 1'b1;
        rollback_pc = 32'h10;
        tick();
        rollback = 1'b0;
        check("rb_no_issue", {31'd0, inst_done}, 32'd0);
        tick();
        expect_req("miss10", 32'h10);

        // jal x1,8 at 0x10 -> 0x18; jal x0,8 at 0x18 -> 0x20
        serve(32'h0080_00EF);
        tick();
        expect_issue("jal10", 32'h0080_00EF, 32'h10, 1'b1);
        tick();
        expect_req("miss18", 32'h18);
        serve(32'h0080_006F);
        tick();
        expect_issue("jal18", 32'h0080_006F, 32'h18, 1'b1);
        tick();
        expect_req("miss20", 32'h20);

        // Rollback during WAIT_MEM abandons the request
        rollback    = 1'b1;
        rollback_pc = 32'h100;
        tick();
        rollback = 1'b0;
        check("rbw_mc_en", {31'd0, mc_en}, 32'd0);
        check("rbw_no_issue", {31'd0, inst_done}, 32'd0);
        tick();
        expect_req("miss100", 32'h100);

        // Stall for three cycles on a hit, then exactly one issue
        serve(32'h0000_0013);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_issue", {31'd0, inst_done}, 32'd0);
            check("stall_no_req", {31'd0, mc_en}, 32'd0);
        end
        stall = 1'b0;
        tick();
        expect_issue("stall_rel", 32'h0000_0013, 32'h100, 1'b0);
        tick();
        check("stall_once", {31'd0, inst_done}, 32'd0);
        expect_req("miss104", 32'h104);

        // rdy=0 ignores a response and keeps the request pending
        rdy     = 1'b0;
        mc_done = 1'b1;
        mc_data = 32'h0000_0067;
        tick();
        rdy     = 1'b1;
        mc_done = 1'b0;
        expect_req("frz_hold", 32'h104);
        tick();
        expect_req("frz_still_wait", 32'h104);
        serve(32'h0000_0013);
        tick();
        expect_issue("nop104", 32'h0000_0013, 32'h104, 1'b0);

        // rdy=0 holds the issue pulse
        rdy = 1'b0;
        tick();
        check("frz_done_hold", {31'd0, inst_done}, 32'd1);
        rdy = 1'b1;
        tick();
        check("unfrz_done", {31'd0, inst_done}, 32'd0);
        expect_req("miss108", 32'h108);

        // Asynchronous reset mid-WAIT_MEM, late response ignored
        #2;
        rst = 1'b0;
        #1;
        check("arst_mc_en", {31'd0, mc_en}, 32'd0);
        check("arst_done", {31'd0, inst_done}, 32'd0);
        check("arst_mc_pc", mc_pc, 32'd0);
        mc_done = 1'b1;
        mc_data = 32'hDEAD_BEEF;
        tick();
        rst = 1'b1;
        tick();
        mc_done = 1'b0;
        expect_req("post_rst_miss0", 32'h0);
        check("post_rst_no_issue", {31'd0, inst_done}, 32'd0);
        tick();
        expect_req("post_rst_wait", 32'h0);
        check("post_rst_no_issue2", {31'd0, inst_done}, 32'd0);
        serve(32'h0000_0093);
        tick();
        expect_issue("refetch0", 32'h0000_0093, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
